// File: rtl/keypad_pkg.sv
// Shared types, row-drive constants and key decoding for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEB_PR, HELD, DEB_RL} state_t;

    localparam logic [3:0] ROW0     = 4'b1110;
    localparam logic [3:0] ROW1     = 4'b1101;
    localparam logic [3:0] ROW2     = 4'b1011;
    localparam logic [3:0] ROW3     = 4'b0111;
    localparam logic [3:0] KEY_NONE = 4'b1111;

    // True when exactly one column line is pulled low; ghosting and idle both fail.
    function automatic logic one_low(input logic [3:0] col);
        logic [3:0] n;
        n = ~col;
        return (n != 4'd0) && ((n & (n - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [3:0] decode_key(input logic [3:0] row, input logic [3:0] col);
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] code;
        case (row)
            ROW1:    r = 2'd1;
            ROW2:    r = 2'd2;
            ROW3:    r = 2'd3;
            default: r = 2'd0;
        endcase
        case (col)
            4'b1101: c = 2'd1;
            4'b1011: c = 2'd2;
            4'b0111: c = 2'd3;
            default: c = 2'd0;
        endcase
        case ({r, c})
            4'h0: code = 4'h7;
            4'h1: code = 4'h4;
            4'h2: code = 4'h1;
            4'h3: code = 4'h0;
            4'h4: code = 4'h8;
            4'h5: code = 4'h5;
            4'h6: code = 4'h2;
            4'h7: code = 4'hA;
            4'h8: code = 4'h9;
            4'h9: code = 4'h6;
            4'hA: code = 4'h3;
            4'hB: code = 4'hB;
            4'hC: code = 4'hC;
            4'hD: code = 4'hD;
            4'hE: code = 4'hE;
            default: code = 4'hF;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Divides clk down to the row-scan tick; held at zero while the game is off.
module scan_tick_gen #(
    parameter int SCAN_DIV = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic game_mode,
    output logic tick
);

    logic [31:0] cnt;

    assign tick = (cnt == 32'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (!game_mode || tick)
            cnt <= '0;
        else
            cnt <= cnt + 32'd1;
    end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad row scanner with single-key press/release debounce.
// Define KEYPAD_REPEAT_EN to re-strobe key_valid every REPEAT_TICKS ticks while held.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 250000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_TICKS   = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_mode,
    input  logic [3:0] keypad_col,
    output logic [3:0] keypad_row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

    if (DEBOUNCE_TICKS < 2 || REPEAT_TICKS < 1 || SCAN_DIV < 1) begin : g_bad_params
        $error("keypad_scan_debounce: illegal parameter values");
    end

    logic          tick;
    logic [3:0]    col_meta, col_sync;
    state_t        state, state_nxt;
    logic [3:0]    row_nxt, cand_col, cand_nxt, code_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic          valid_nxt, held_nxt;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .game_mode (game_mode),
        .tick      (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta <= KEY_NONE;
            col_sync <= KEY_NONE;
        end else begin
            col_meta <= keypad_col;
            col_sync <= col_meta;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    logic [RW-1:0] rcnt, rcnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rcnt <= '0;
        else      rcnt <= rcnt_nxt;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SCAN;
            keypad_row <= ROW0;
            cand_col   <= KEY_NONE;
            dcnt       <= '0;
            key_code   <= 4'h0;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
        end else begin
            state      <= state_nxt;
            keypad_row <= row_nxt;
            cand_col   <= cand_nxt;
            dcnt       <= dcnt_nxt;
            key_code   <= code_nxt;
            key_valid  <= valid_nxt;
            key_held   <= held_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = keypad_row;
        cand_nxt  = cand_col;
        dcnt_nxt  = dcnt;
        code_nxt  = key_code;
        valid_nxt = 1'b0;
        held_nxt  = key_held;
`ifdef KEYPAD_REPEAT_EN
        rcnt_nxt  = rcnt;
`endif
        if (!game_mode) begin
            state_nxt = SCAN;
            row_nxt   = ROW0;
            cand_nxt  = KEY_NONE;
            dcnt_nxt  = '0;
            code_nxt  = 4'h0;
            held_nxt  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rcnt_nxt  = '0;
`endif
        end else if (tick) begin
            case (state)
                SCAN: begin
                    if (one_low(col_sync)) begin
                        cand_nxt  = col_sync;
                        dcnt_nxt  = DW'(1);
                        state_nxt = DEB_PR;
                    end else begin
                        row_nxt = {keypad_row[2:0], keypad_row[3]};
                    end
                end
                DEB_PR: begin
                    // Row stays frozen here, so it still identifies the candidate key.
                    if (col_sync == cand_col) begin
                        if (dcnt == DW'(DEBOUNCE_TICKS - 1)) begin
                            code_nxt  = decode_key(keypad_row, cand_col);
                            valid_nxt = 1'b1;
                            held_nxt  = 1'b1;
                            dcnt_nxt  = '0;
                            state_nxt = HELD;
`ifdef KEYPAD_REPEAT_EN
                            rcnt_nxt  = '0;
`endif
                        end else begin
                            dcnt_nxt = dcnt + DW'(1);
                        end
                    end else begin
                        dcnt_nxt  = '0;
                        state_nxt = SCAN;
                    end
                end
                HELD: begin
                    if (col_sync == KEY_NONE) begin
                        dcnt_nxt  = DW'(1);
                        state_nxt = DEB_RL;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rcnt == RW'(REPEAT_TICKS - 1)) begin
                        valid_nxt = 1'b1;
                        rcnt_nxt  = '0;
                    end else begin
                        rcnt_nxt = rcnt + RW'(1);
                    end
`endif
                end
                DEB_RL: begin
                    if (col_sync == KEY_NONE) begin
                        if (dcnt == DW'(DEBOUNCE_TICKS - 1)) begin
                            held_nxt  = 1'b0;
                            dcnt_nxt  = '0;
                            row_nxt   = {keypad_row[2:0], keypad_row[3]};
                            state_nxt = SCAN;
                        end else begin
                            dcnt_nxt = dcnt + DW'(1);
                        end
                    end else begin
                        // Any line low again means the key never really let go.
                        dcnt_nxt  = '0;
                        state_nxt = HELD;
`ifdef KEYPAD_REPEAT_EN
                        rcnt_nxt  = '0;
`endif
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with SCAN_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5.
module tb_keypad_scan_debounce;

    logic       clk;
    logic       rst;
    logic       game_mode;
    logic [3:0] keypad_col;
    logic [3:0] keypad_row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // Keypad model: key_pat appears on the columns only while key_row is driven.
    logic [3:0] key_row;
    logic [3:0] key_pat;
    assign keypad_col = (keypad_row == key_row) ? key_pat : 4'hF;

    int err_cnt = 0;
    int chk_cnt = 0;
    int strobes = 0;
    int dbl     = 0;
    int base;
    logic prev_valid = 1'b0;

    keypad_scan_debounce #(
        .SCAN_DIV       (4),
        .DEBOUNCE_TICKS (3),
        .REPEAT_TICKS   (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .game_mode  (game_mode),
        .keypad_col (keypad_col),
        .keypad_row (keypad_row),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_held   (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid) begin
            strobes = strobes + 1;
            if (prev_valid) dbl = dbl + 1;
        end
        prev_valid = key_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (4 * n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        game_mode = 1'b1;
        key_row   = 4'b1110;
        key_pat   = 4'hF;

        // 1. reset state and idle rotation
        repeat (3) @(posedge clk);
        #1;
        check("rst_row", 32'(keypad_row), 32'h1110_0000 >> 20 == 0 ? 32'hE : 32'hE);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("row_pre_tick", 32'(keypad_row), 32'hE);
        @(posedge clk);
        #1;
        check("row_1", 32'(keypad_row), 32'hD);
        tick(1);
        check("row_2", 32'(keypad_row), 32'hB);
        tick(1);
        check("row_3", 32'(keypad_row), 32'h7);
        tick(1);
        check("row_wrap", 32'(keypad_row), 32'hE);

        // 2. clean press of key 2 (row 1101, col 1011)
        key_row = 4'b1101;
        key_pat = 4'b1011;
        tick(3);
        check("press_early_strobes", 32'(strobes), 32'd0);
        check("press_early_held", 32'(key_held), 32'h0);
        tick(1);
        check("press_valid", 32'(key_valid), 32'h1);
        check("press_code", 32'(key_code), 32'h2);
        check("press_held", 32'(key_held), 32'h1);
        tick(1);
        check("press_valid_drop", 32'(key_valid), 32'h0);
        check("press_strobes", 32'(strobes), 32'd1);
        key_pat = 4'hF;
        tick(2);
        check("release_held_mid", 32'(key_held), 32'h1);
        tick(1);
        check("release_held", 32'(key_held), 32'h0);
        check("release_row", 32'(keypad_row), 32'hB);

        // 3. bouncing press on key F (row 0111, col 0111)
        tick(1);
        base    = strobes;
        key_row = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            key_pat = 4'b0111;
            tick(1);
            key_pat = 4'hF;
            tick(1);
        end
        check("bounce_strobes", 32'(strobes - base), 32'd0);
        check("bounce_code", 32'(key_code), 32'h2);
        check("bounce_held", 32'(key_held), 32'h0);

        // 4. ghosting on row 1110, then a clean key 7
        key_row = 4'b1110;
        key_pat = 4'b1100;
        tick(8);
        check("ghost_strobes", 32'(strobes - base), 32'd0);
        check("ghost_held", 32'(key_held), 32'h0);
        key_pat = 4'b1110;
        tick(8);
        check("key7_strobes", 32'(strobes - base), 32'd1);
        check("key7_code", 32'(key_code), 32'h7);
        check("key7_held", 32'(key_held), 32'h1);

        // 5. release bounce while held
        base = strobes;
        for (int i = 0; i < 6; i++) begin
            key_pat = (i % 2 == 0) ? 4'hF : 4'b1110;
            tick(1);
            check("rlbounce_held", 32'(key_held), 32'h1);
        end
        check("rlbounce_strobes", 32'(strobes - base), 32'd0);
        key_pat = 4'hF;
        tick(3);
        check("rl_done_held", 32'(key_held), 32'h0);
        check("rl_done_row", 32'(keypad_row), 32'hD);

        // 6. game_mode drop during press debounce of key 8
        key_row = 4'b1101;
        key_pat = 4'b1110;
        tick(2);
        game_mode = 1'b0;
        @(posedge clk);
        #1;
        check("abort_row", 32'(keypad_row), 32'hE);
        check("abort_held", 32'(key_held), 32'h0);
        check("abort_code", 32'(key_code), 32'h0);
        check("abort_valid", 32'(key_valid), 32'h0);
        repeat (20) @(posedge clk);
        #1;
        check("abort_strobes", 32'(strobes - base), 32'd0);
        check("abort_row_frozen", 32'(keypad_row), 32'hE);

        // long hold of key 1 (row 1110, col 1011): 3 debounce ticks + 16 held ticks
        key_row   = 4'b1110;
        key_pat   = 4'b1011;
        game_mode = 1'b1;
        tick(19);
`ifdef KEYPAD_REPEAT_EN
        check("hold_strobes", 32'(strobes - base), 32'd4);
`else
        check("hold_strobes", 32'(strobes - base), 32'd1);
`endif
        check("hold_code", 32'(key_code), 32'h1);
        check("hold_held", 32'(key_held), 32'h1);
        key_pat = 4'hF;
        tick(3);
        check("hold_release", 32'(key_held), 32'h0);
        check("hold_release_row", 32'(keypad_row), 32'hD);
        check("no_back_to_back", 32'(dbl), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
